ps2_receive: RTL and testbench

//   Device-to-host half of the PS/2 link: samples the open-collector ps2_clock/ps2_data lines,

---
 rtl/ps2_pkg.sv | 15 +
 rtl/ps2_receive_if.sv | 23 ++
 rtl/ps2_filter.sv | 49 ++++
 rtl/ps2_receive.sv | 115 +++++++++++
 tb/tb_ps2_receive.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 frame constants, receive-state type and parity helper
package ps2_pkg;

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_rx_state_t;

   localparam logic PS2_START_BIT = 1'b0;
   localparam logic PS2_STOP_BIT  = 1'b1;
   localparam int   PS2_DATA_BITS = 8;

   // PS/2 uses odd parity: data bits plus parity bit must hold an odd number of ones
   function automatic logic ps2_parity_ok(input logic [PS2_DATA_BITS-1:0] data, input logic parity);
      return ^{data, parity};
   endfunction

endpackage

// File: rtl/ps2_receive_if.sv
// rtl/ps2_receive_if.sv - pin and byte-output bundle of the PS/2 receiver
interface ps2_receive_if;
   import ps2_pkg::*;

   logic                     enable;
   logic                     ps2_clock;
   logic                     ps2_data;
   logic [PS2_DATA_BITS-1:0] rx_data;
   logic                     rx_valid;
   logic                     rx_error;
   logic                     busy;

   modport master (
      output enable, ps2_clock, ps2_data,
      input  rx_data, rx_valid, rx_error, busy
   );

   modport slave (
      input  enable, ps2_clock, ps2_data,
      output rx_data, rx_valid, rx_error, busy
   );

endinterface

// File: rtl/ps2_filter.sv
// rtl/ps2_filter.sv - pin synchronizer, saturating glitch filter and falling-edge strobe
module ps2_filter #(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic i_pin,
   output logic o_fall
);

   localparam int CW = $clog2(FILTER_LEN + 1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic [CW-1:0]          r_cnt;
   logic                   r_level;
   logic                   r_fall;
   logic                   w_sample;

   assign w_sample = r_sync[SYNC_STAGES-1];
   assign o_fall   = r_fall;

   // Synchronizer chain, preset high so an idle bus looks idle straight out of reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_sync <= '1;
      else        r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
   end

   // Level only flips after FILTER_LEN consecutive disagreeing samples; strobe is registered with the flip
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt   <= '0;
         r_level <= 1'b1;
         r_fall  <= 1'b0;
      end else begin
         r_fall <= 1'b0;
         if (w_sample == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt == CW'(FILTER_LEN - 1)) begin
            r_cnt   <= '0;
            r_level <= w_sample;
            r_fall  <= ~w_sample;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/ps2_receive.sv
// rtl/ps2_receive.sv - PS/2 device-to-host frame receiver with parity, stop and timeout checks
module ps2_receive
   import ps2_pkg::*;
#(
   parameter int SYNC_STAGES    = 2,
   parameter int FILTER_LEN     = 4,
   parameter int TIMEOUT_CYCLES = 100_000
) (
   input  logic          clk,
   input  logic          reset,
   ps2_receive_if.slave  bus
);

   localparam int            TW      = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

   ps2_rx_state_t            r_state;
   logic [2:0]               r_bitcnt;
   logic [TW-1:0]            r_tocnt;
   logic [PS2_DATA_BITS-1:0] r_shift;
   logic                     r_parity;
   logic [PS2_DATA_BITS-1:0] r_rx_data;
   logic                     r_rx_valid;
   logic                     r_rx_error;
   logic [SYNC_STAGES-1:0]   r_data_sync;

   logic w_fall;
   logic w_data;
   logic w_timeout;

   ps2_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN)
   ) u_clk_filter (
      .clk    (clk),
      .reset  (reset),
      .i_pin  (bus.ps2_clock),
      .o_fall (w_fall)
   );

   // Data pin only needs synchronizing: it is sampled FILTER_LEN cycles after the clock edge, long after it settled
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_data_sync <= '1;
      else        r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], bus.ps2_data};
   end

   assign w_data    = r_data_sync[SYNC_STAGES-1];
   // A clock edge arriving on the last allowed cycle still counts, so the edge wins over the timeout
   assign w_timeout = (r_state != IDLE) && !w_fall && (r_tocnt == TO_LAST);

   // Frame FSM with registered byte, strobes, bit counter and inter-edge timeout counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= IDLE;
         r_bitcnt   <= '0;
         r_tocnt    <= '0;
         r_shift    <= '0;
         r_parity   <= 1'b0;
         r_rx_data  <= '0;
         r_rx_valid <= 1'b0;
         r_rx_error <= 1'b0;
      end else begin
         r_rx_valid <= 1'b0;
         r_rx_error <= 1'b0;
         if (!bus.enable) begin
            r_state  <= IDLE;
            r_bitcnt <= '0;
            r_tocnt  <= '0;
         end else begin
            if (w_fall || r_state == IDLE) r_tocnt <= '0;
            else                           r_tocnt <= r_tocnt + 1'b1;

            if (w_timeout) begin
               r_rx_error <= 1'b1;
               r_state    <= IDLE;
            end else if (w_fall) begin
               case (r_state)
                  IDLE: begin
                     if (w_data == PS2_START_BIT) begin
                        r_state  <= DATA;
                        r_bitcnt <= '0;
                        r_shift  <= '0;
                     end
                  end
                  DATA: begin
                     r_shift  <= {w_data, r_shift[PS2_DATA_BITS-1:1]};
                     r_bitcnt <= r_bitcnt + 1'b1;
                     if (r_bitcnt == 3'(PS2_DATA_BITS - 1)) r_state <= PARITY;
                  end
                  PARITY: begin
                     r_parity <= w_data;
                     r_state  <= STOP;
                  end
                  STOP: begin
                     if (w_data == PS2_STOP_BIT && ps2_parity_ok(r_shift, r_parity)) begin
                        r_rx_data  <= r_shift;
                        r_rx_valid <= 1'b1;
                     end else begin
                        r_rx_error <= 1'b1;
                     end
                     r_state <= IDLE;
                  end
                  default: r_state <= IDLE;
               endcase
            end
         end
      end
   end

   assign bus.rx_data  = r_rx_data;
   assign bus.rx_valid = r_rx_valid;
   assign bus.rx_error = r_rx_error;
   assign bus.busy     = (r_state != IDLE);

endmodule

// File: tb/tb_ps2_receive.sv
// tb/tb_ps2_receive.sv - scoreboard bench for ps2_receive driven by a PS/2 device model
module tb_ps2_receive;
   import ps2_pkg::*;

   localparam int SYNC = 2;
   localparam int FLEN = 4;
   localparam int TOUT = 1500;
   localparam int HALF = 40;
   localparam int QTR  = 20;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   ps2_receive_if bus ();

   ps2_receive #(
      .SYNC_STAGES    (SYNC),
      .FILTER_LEN     (FLEN),
      .TIMEOUT_CYCLES (TOUT)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #10 clk = ~clk;

   typedef struct {
      bit         is_err;
      logic [7:0] data;
   } exp_t;

   exp_t       exp_q[$];
   exp_t       mon_e;
   int         checks   = 0;
   int         failures = 0;
   logic [7:0] last_good = 8'h00;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Device model: data set while clock high, then a low half-period; optional 3-cycle glitch in the high phase
   task automatic ps2_bit(input logic b, input bit glitch);
      bus.ps2_data = b;
      wait_clk(QTR);
      bus.ps2_clock = 1'b0;
      wait_clk(HALF);
      bus.ps2_clock = 1'b1;
      if (glitch) begin
         wait_clk(10);
         bus.ps2_clock = 1'b0;
         wait_clk(3);
         bus.ps2_clock = 1'b1;
         wait_clk(7);
      end else begin
         wait_clk(QTR);
      end
   endtask

   function automatic logic [10:0] make_frame(input logic [7:0] d, input bit good_par, input logic stop);
      logic p;
      p = ($countones(d) % 2 == 0);
      if (!good_par) p = ~p;
      return {stop, p, d, PS2_START_BIT};
   endfunction

   task automatic send(input logic [10:0] f, input int nbits, input int glitch_at);
      for (int i = 0; i < nbits; i++) ps2_bit(f[i], i == glitch_at);
      bus.ps2_data = 1'b1;
      wait_clk(QTR);
   endtask

   // Reference: a full frame is good iff start=0, stop=1 and data+parity has an odd count of ones
   task automatic frame(input logic [7:0] d, input bit good_par, input logic stop, input int glitch_at);
      logic [10:0] f;
      exp_t        e;
      f        = make_frame(d, good_par, stop);
      e.is_err = !((f[0] == 1'b0) && (f[10] == 1'b1) && ($countones(f[9:1]) % 2 == 1));
      e.data   = d;
      exp_q.push_back(e);
      send(f, 11, glitch_at);
   endtask

   task automatic drain(input string name);
      wait_clk(20);
      check(name, exp_q.size(), 0);
   endtask

   // Monitor: every strobe pops one expectation and checks kind and presented byte
   always @(negedge clk) begin
      if (!reset) begin
         last_good = 8'h00;
      end else if (bus.rx_valid || bus.rx_error) begin
         check("valid_error_exclusive", {31'd0, bus.rx_valid & bus.rx_error}, 0);
         if (exp_q.size() == 0) begin
            check("unexpected_pulse", {30'd0, bus.rx_valid, bus.rx_error}, 0);
         end else begin
            mon_e = exp_q.pop_front();
            check("pulse_is_error", {31'd0, bus.rx_error}, {31'd0, mon_e.is_err});
            if (!mon_e.is_err) last_good = mon_e.data;
            check("rx_data_at_pulse", {24'd0, bus.rx_data}, {24'd0, last_good});
         end
      end
   end

   initial begin
      logic [10:0] f;
      exp_t        e;
      bus.enable    = 1'b1;
      bus.ps2_clock = 1'b1;
      bus.ps2_data  = 1'b1;
      reset         = 1'b0;
      wait_clk(5);
      check("reset_rx_data",  {24'd0, bus.rx_data}, 0);
      check("reset_rx_valid", {31'd0, bus.rx_valid}, 0);
      check("reset_rx_error", {31'd0, bus.rx_error}, 0);
      check("reset_busy",     {31'd0, bus.busy}, 0);
      reset = 1'b1;
      wait_clk(10);

      frame(8'h1C, 1'b1, 1'b1, -1);
      drain("drain_1C");
      check("rx_data_1C", {24'd0, bus.rx_data}, 32'h1C);

      frame(8'hF0, 1'b0, 1'b1, -1);
      drain("drain_F0_bad_parity");
      check("rx_data_kept_1C", {24'd0, bus.rx_data}, 32'h1C);

      frame(8'h5A, 1'b1, 1'b0, -1);
      drain("drain_5A_bad_stop");
      frame(8'h5A, 1'b1, 1'b1, -1);
      drain("drain_5A");
      check("rx_data_5A", {24'd0, bus.rx_data}, 32'h5A);

      // Partial frame: start plus four data bits, then silence
      e.is_err = 1'b1;
      e.data   = 8'h00;
      exp_q.push_back(e);
      send(make_frame(8'hE0, 1'b1, 1'b1), 5, -1);
      check("busy_partial", {31'd0, bus.busy}, 1);
      wait_clk(TOUT + 20);
      check("drain_timeout", exp_q.size(), 0);
      check("busy_after_timeout", {31'd0, bus.busy}, 0);
      frame(8'hE0, 1'b1, 1'b1, -1);
      drain("drain_E0");
      check("rx_data_E0", {24'd0, bus.rx_data}, 32'hE0);

      // Glitch while idle, then glitch inside a frame
      bus.ps2_clock = 1'b0;
      wait_clk(3);
      bus.ps2_clock = 1'b1;
      wait_clk(30);
      check("busy_idle_glitch", {31'd0, bus.busy}, 0);
      frame(8'hA5, 1'b1, 1'b1, 3);
      drain("drain_A5_glitch");
      check("rx_data_A5", {24'd0, bus.rx_data}, 32'hA5);

      // Disable after data bit 5; remainder of the frame goes by while disabled
      f = make_frame(8'h12, 1'b1, 1'b1);
      for (int i = 0; i < 7; i++) ps2_bit(f[i], 1'b0);
      check("busy_before_disable", {31'd0, bus.busy}, 1);
      bus.enable = 1'b0;
      wait_clk(1);
      check("busy_after_disable", {31'd0, bus.busy}, 0);
      for (int i = 7; i < 11; i++) ps2_bit(f[i], 1'b0);
      bus.ps2_data = 1'b1;
      wait_clk(QTR);
      bus.enable = 1'b1;
      drain("drain_disabled_frame");

      // Reset in the middle of a frame
      send(make_frame(8'h3C, 1'b1, 1'b1), 4, -1);
      reset = 1'b0;
      #1;
      check("midreset_rx_data",  {24'd0, bus.rx_data}, 0);
      check("midreset_rx_valid", {31'd0, bus.rx_valid}, 0);
      check("midreset_rx_error", {31'd0, bus.rx_error}, 0);
      check("midreset_busy",     {31'd0, bus.busy}, 0);
      wait_clk(5);
      reset = 1'b1;
      wait_clk(10);
      frame(8'h12, 1'b1, 1'b1, -1);
      drain("drain_12");
      check("rx_data_12", {24'd0, bus.rx_data}, 32'h12);

      // Random back-to-back frames with occasional corruption and glitches
      for (int n = 0; n < 12; n++) begin
         logic [7:0] d;
         bit         gp;
         logic       st;
         int         g;
         d  = 8'($urandom_range(0, 255));
         gp = ($urandom_range(0, 3) != 0);
         st = ($urandom_range(0, 7) != 0);
         g  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 10)) : -1;
         frame(d, gp, st, g);
      end
      drain("drain_random");
      check("rx_data_final", {24'd0, bus.rx_data}, {24'd0, last_good});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
